regbank_wr_arbiter: RTL and testbench

Shares the single write port of the 32-entry register bank (`RegEscr`, `EscrReg`, `datain`) between two writeback requesters: A (ALU result path) and B (load/memory return path). It arbitrates round-robin with valid/ready handshakes and drives the bank's write port from a registered stage. It also keeps a busy scoreboard of destination registers that have been reserved but not yet written, which issue logic uses to stall dependent reads.

---
 rtl/regbank_wr_arbiter.sv | 99 +++++++++
 tb/tb_regbank_wr_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_wr_arbiter.sv
// Round-robin writeback arbiter for the register bank write port, with a
// registered write stage and a busy scoreboard of reserved destinations.
module regbank_wr_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [NREG-1:0]   busy
);

    localparam logic [ADDR_W:0] NREG_L = (ADDR_W + 1)'(NREG);

    // Register 0 and indices beyond the bank are never written or tracked.
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
        return (addr != '0) && ({1'b0, addr} < NREG_L);
    endfunction

    // last_grant_q: 1 means B was granted most recently.
    logic              last_grant_q, last_grant_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              rsv_legal;

    assign a_ready = a_valid & (~b_valid | last_grant_q) & ~rst;
    assign b_ready = b_valid & (~a_valid | ~last_grant_q) & ~rst;

    always_comb begin
        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        sel_addr     = a_ready ? a_addr : b_addr;
        sel_data     = a_ready ? a_data : b_data;
        if (a_ready | b_ready) begin
            last_grant_d = b_ready;
            if (addr_legal(sel_addr)) begin
                wr_en_d   = 1'b1;
                wr_addr_d = sel_addr;
                wr_data_d = sel_data;
            end
        end
    end

    assign rsv_legal = rsv_en & addr_legal(rsv_addr);

    // A new reservation outranks the clear from an older producer's write.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
        always_comb begin
            busy_d[gi] = busy_q[gi];
            if (wr_en_q && (wr_addr_q == ADDR_W'(gi))) begin
                busy_d[gi] = 1'b0;
            end
            if (rsv_legal && (rsv_addr == ADDR_W'(gi))) begin
                busy_d[gi] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Bench for regbank_wr_arbiter: behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regbank_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0, rsv_en = 1'b0;
    logic        a_ready, b_ready, wr_en;
    logic [5:0]  a_addr = '0, b_addr = '0, rsv_addr = '0, wr_addr;
    logic [31:0] a_data = '0, b_data = '0, wr_data, busy;

    int checks = 0;
    int errors = 0;

    regbank_wr_arbiter #(.DATA_W(32), .ADDR_W(6), .NREG(32)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic bit legal(input logic [5:0] addr);
        return (addr != 0) && (addr < 32);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: last granted requester, pending bank write, busy set.
    logic        m_lg = 1'b1;
    logic        m_en = 1'b0;
    logic [5:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_busy = '0;
    bit          m_ok = 1'b0;

    always @(posedge clk) begin
        logic        ga, gb;
        logic [31:0] nb;
        logic [5:0]  sa;
        if (rst) begin
            m_lg <= 1'b1; m_en <= 1'b0; m_addr <= '0; m_data <= '0;
            m_busy <= '0; m_ok <= 1'b1;
        end else begin
            ga = a_valid && (!b_valid || m_lg);
            gb = b_valid && !ga;
            nb = m_busy;
            if (m_en) nb[m_addr[4:0]] = 1'b0;
            if (rsv_en && legal(rsv_addr)) nb[rsv_addr[4:0]] = 1'b1;
            m_busy <= nb;
            m_en <= 1'b0;
            sa = ga ? a_addr : b_addr;
            if (ga || gb) begin
                m_lg <= gb;
                if (legal(sa)) begin
                    m_en   <= 1'b1;
                    m_addr <= sa;
                    m_data <= ga ? a_data : b_data;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("a_ready", a_ready, !rst && a_valid && (!b_valid || m_lg));
            chk("b_ready", b_ready, !rst && b_valid && (!a_valid || !m_lg));
            chk("wr_en", wr_en, m_en);
            chk("wr_addr", wr_addr, m_addr);
            chk("wr_data", wr_data, m_data);
            chk("busy", busy, m_busy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; rsv_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] bsnap;
    logic        acc_a, acc_b;

    initial begin
        // Reset with A requesting: ready must stay low.
        a_valid = 1'b1; a_addr = 6'd5;
        @(negedge clk);
        chk("rst_a_ready", a_ready, 1'b0);
        do_reset();
        @(negedge clk);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_addr", wr_addr, 6'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_busy", busy, 32'd0);

        // A only
        a_valid = 1'b1; a_addr = 6'd5; a_data = 32'h1234;
        @(negedge clk);
        chk("t1_a_ready", a_ready, 1'b1);
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        chk("t1_wr_en", wr_en, 1'b1);
        chk("t1_wr_addr", wr_addr, 6'd5);
        chk("t1_wr_data", wr_data, 32'h1234);
        tick();
        @(negedge clk);
        chk("t1_wr_en_off", wr_en, 1'b0);
        tick();

        // Both valid: A,B,A,B
        do_reset();
        a_valid = 1'b1; a_addr = 6'd3; a_data = 32'haaaa;
        b_valid = 1'b1; b_addr = 6'd7; b_data = 32'hbbbb;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_a_ready", a_ready, (k % 2) == 0);
            chk("t2_b_ready", b_ready, (k % 2) == 1);
            if (k > 0) chk("t2_wr_addr", wr_addr, (k % 2) == 1 ? 6'd3 : 6'd7);
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        chk("t2_last_en", wr_en, 1'b1);
        chk("t2_last_addr", wr_addr, 6'd7);
        chk("t2_last_data", wr_data, 32'hbbbb);
        tick();

        // Scoreboard round trip on register 9
        rsv_en = 1'b1; rsv_addr = 6'd9;
        tick();
        rsv_en = 1'b0;
        @(negedge clk);
        chk("t3_busy9_set", busy[9], 1'b1);
        tick();
        tick();
        b_valid = 1'b1; b_addr = 6'd9; b_data = 32'h99;
        @(negedge clk);
        chk("t3_b_ready", b_ready, 1'b1);
        tick();
        b_valid = 1'b0;
        @(negedge clk);
        chk("t3_wr_en", wr_en, 1'b1);
        chk("t3_busy9_held", busy[9], 1'b1);
        tick();
        @(negedge clk);
        chk("t3_busy9_clr", busy[9], 1'b0);
        tick();

        // Same-cycle reserve and clear: reserve wins
        rsv_en = 1'b1; rsv_addr = 6'd9;
        tick();
        rsv_en = 1'b0; b_valid = 1'b1; b_addr = 6'd9; b_data = 32'h77;
        tick();
        b_valid = 1'b0; rsv_en = 1'b1; rsv_addr = 6'd9;
        @(negedge clk);
        chk("t4_wr_en", wr_en, 1'b1);
        chk("t4_wr_addr", wr_addr, 6'd9);
        tick();
        rsv_en = 1'b0;
        @(negedge clk);
        chk("t4_busy9", busy[9], 1'b1);
        tick();

        // Zero and out-of-range addresses: accepted, never written
        a_valid = 1'b1; a_addr = 6'd0; a_data = 32'hdead;
        @(negedge clk);
        bsnap = busy;
        chk("t5_ready_a0", a_ready, 1'b1);
        tick();
        a_addr = 6'd40;
        @(negedge clk);
        chk("t5_ready_a40", a_ready, 1'b1);
        chk("t5_wr_en_a0", wr_en, 1'b0);
        tick();
        a_addr = 6'd4; b_valid = 1'b1; b_addr = 6'd6; b_data = 32'h66;
        @(negedge clk);
        chk("t5_wr_en_a40", wr_en, 1'b0);
        chk("t5_busy", busy, bsnap);
        chk("t5_wr_addr_hold", wr_addr, 6'd9);
        chk("t5_tie_b", b_ready, 1'b1);
        chk("t5_tie_a", a_ready, 1'b0);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        chk("t5_b_addr", wr_addr, 6'd6);
        tick();

        // Reset mid-operation
        a_valid = 1'b1; a_addr = 6'd5; a_data = 32'h55; rsv_en = 1'b1; rsv_addr = 6'd11;
        @(negedge clk);
        chk("t6_a_ready", a_ready, 1'b1);
        tick();
        rst = 1'b1; rsv_en = 1'b0; b_valid = 1'b1; b_addr = 6'd8;
        @(negedge clk);
        chk("t6_rst_a_ready", a_ready, 1'b0);
        chk("t6_rst_b_ready", b_ready, 1'b0);
        tick();
        @(negedge clk);
        chk("t6_rst_wr_en", wr_en, 1'b0);
        chk("t6_rst_busy", busy, 32'd0);
        chk("t6_rst_b_ready2", b_ready, 1'b0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_tie_a", a_ready, 1'b1);
        chk("t6_tie_b", b_ready, 1'b0);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        tick();

        // Randomized traffic; requests held until accepted
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            acc_a = a_valid && a_ready;
            acc_b = b_valid && b_ready;
            tick();
            rst = ($urandom_range(0, 299) == 0);
            if (!a_valid || acc_a) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_addr  = 6'($urandom_range(0, 40));
                a_data  = $urandom;
            end
            if (!b_valid || acc_b) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_addr  = 6'($urandom_range(0, 40));
                b_data  = $urandom;
            end
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = 6'($urandom_range(0, 40));
        end
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; rsv_en = 1'b0;
        tick();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
